// File: rtl/plot_arbiter_if.sv
`default_nettype none
// ============================================================================
// plot_arbiter_if : request/pixel bus between the drawers and the VGA arbiter
// Revision: 1.0
// ============================================================================
interface plot_arbiter_if;
    logic [2:0]  req;
    logic [23:0] x_in;
    logic [20:0] y_in;
    logic [8:0]  colour_in;
    logic [2:0]  ack;
    logic        busy;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;

    modport master (
        output req, x_in, y_in, colour_in,
        input  ack, busy, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  req, x_in, y_in, colour_in,
        output ack, busy, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface
`default_nettype wire

// File: rtl/plot_arbiter.sv
`default_nettype none
// ============================================================================
// plot_arbiter : round-robin sharing of the VGA write port, one box per grant
// Revision: 1.0
// ============================================================================
module plot_arbiter #(
    parameter int BOX_W = 4,
    parameter int BOX_H = 4,
    parameter int X_MAX = 160,
    parameter int Y_MAX = 120
) (
    input  wire logic       clk,
    input  wire logic       reset,
    plot_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] C_CX_LAST = 4'(BOX_W - 1);
    localparam logic [3:0] C_CY_LAST = 4'(BOX_H - 1);
    localparam logic [8:0] C_X_MAX   = 9'(X_MAX);
    localparam logic [7:0] C_Y_MAX   = 8'(Y_MAX);

    state_t     r_state;
    logic [1:0] r_last;
    logic [7:0] r_base_x;
    logic [6:0] r_base_y;
    logic [2:0] r_colour;
    logic [3:0] r_cx;
    logic [3:0] r_cy;
    logic [2:0] r_ack;
    logic       r_busy;
    logic [7:0] r_vga_x;
    logic [6:0] r_vga_y;
    logic [2:0] r_vga_colour;
    logic       r_vga_plot;

    logic       w_any;
    logic [1:0] w_grant;
    logic [7:0] w_sel_x;
    logic [6:0] w_sel_y;
    logic [2:0] w_sel_colour;
    logic       w_row_end;
    logic       w_last_px;
    logic [3:0] w_ncx;
    logic [3:0] w_ncy;
    logic [7:0] w_px_bx;
    logic [6:0] w_px_by;
    logic [3:0] w_px_cx;
    logic [3:0] w_px_cy;
    logic [8:0] w_sum_x;
    logic [7:0] w_sum_y;
    logic       w_on_screen;

    // Search order starts just after the last winner so every requester rotates to the front.
    always_comb begin
        w_any   = |bus.req;
        w_grant = 2'd0;
        case (r_last)
            2'd0:    w_grant = bus.req[1] ? 2'd1 : (bus.req[2] ? 2'd2 : 2'd0);
            2'd1:    w_grant = bus.req[2] ? 2'd2 : (bus.req[0] ? 2'd0 : 2'd1);
            default: w_grant = bus.req[0] ? 2'd0 : (bus.req[1] ? 2'd1 : 2'd2);
        endcase
    end

    assign w_sel_x      = bus.x_in[8*w_grant +: 8];
    assign w_sel_y      = bus.y_in[7*w_grant +: 7];
    assign w_sel_colour = bus.colour_in[3*w_grant +: 3];

    assign w_row_end = (r_cx == C_CX_LAST);
    assign w_last_px = w_row_end && (r_cy == C_CY_LAST);
    assign w_ncx     = w_row_end ? 4'd0 : r_cx + 4'd1;
    assign w_ncy     = w_row_end ? r_cy + 4'd1 : r_cy;

    // Outputs are registered, so the pixel being loaded is the one for the next cycle.
    assign w_px_bx     = (r_state == S_IDLE) ? w_sel_x : r_base_x;
    assign w_px_by     = (r_state == S_IDLE) ? w_sel_y : r_base_y;
    assign w_px_cx     = (r_state == S_IDLE) ? 4'd0 : w_ncx;
    assign w_px_cy     = (r_state == S_IDLE) ? 4'd0 : w_ncy;
    assign w_sum_x     = {1'b0, w_px_bx} + {5'b0, w_px_cx};
    assign w_sum_y     = {1'b0, w_px_by} + {4'b0, w_px_cy};
    assign w_on_screen = (w_sum_x < C_X_MAX) && (w_sum_y < C_Y_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last       <= 2'd2;
            r_base_x     <= 8'd0;
            r_base_y     <= 7'd0;
            r_colour     <= 3'd0;
            r_cx         <= 4'd0;
            r_cy         <= 4'd0;
            r_ack        <= 3'd0;
            r_busy       <= 1'b0;
            r_vga_x      <= 8'd0;
            r_vga_y      <= 7'd0;
            r_vga_colour <= 3'd0;
            r_vga_plot   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_last       <= w_grant;
                        r_base_x     <= w_sel_x;
                        r_base_y     <= w_sel_y;
                        r_colour     <= w_sel_colour;
                        r_cx         <= 4'd0;
                        r_cy         <= 4'd0;
                        r_busy       <= 1'b1;
                        r_vga_x      <= w_sum_x[7:0];
                        r_vga_y      <= w_sum_y[6:0];
                        r_vga_colour <= w_sel_colour;
                        r_vga_plot   <= w_on_screen;
                        r_state      <= S_DRAW;
                    end
                end
                S_DRAW: begin
                    if (w_last_px) begin
                        r_vga_plot <= 1'b0;
                        r_ack      <= 3'b001 << r_last;
                        r_state    <= S_DONE;
                    end else begin
                        r_cx         <= w_ncx;
                        r_cy         <= w_ncy;
                        r_vga_x      <= w_sum_x[7:0];
                        r_vga_y      <= w_sum_y[6:0];
                        r_vga_colour <= r_colour;
                        r_vga_plot   <= w_on_screen;
                    end
                end
                S_DONE: begin
                    r_ack   <= 3'd0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ack      <= 3'd0;
                    r_busy     <= 1'b0;
                    r_vga_plot <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ack        = r_ack;
    assign bus.busy       = r_busy;
    assign bus.vga_x      = r_vga_x;
    assign bus.vga_y      = r_vga_y;
    assign bus.vga_colour = r_vga_colour;
    assign bus.vga_plot   = r_vga_plot;
endmodule
`default_nettype wire
